// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - state encodings, mode codes and clock defaults for the buzzer pattern generator
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BEEP  = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam int CLK_HZ       = 50_000_000;
  localparam int DEF_TICK_CYC = CLK_HZ / 1000;

endpackage

// File: rtl/buzzer_tick_gen.sv
// rtl/buzzer_tick_gen.sv - clearable prescaler emitting a one-cycle tick every TICK_CYC clocks
module buzzer_tick_gen #(
  parameter int TICK_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYC - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/buzzer_pattern_gen.sv
// rtl/buzzer_pattern_gen.sv - OFF/CONT/BEEP/BURST buzzer pattern FSM; BUZZER_TONE_EN adds a square-wave tone on M
module buzzer_pattern_gen
  import buzzer_pkg::*;
#(
  parameter int CS_W          = 3,
  parameter int LEN_W         = 12,
  parameter int CNT_W         = 4,
  parameter int TICK_CYC      = DEF_TICK_CYC,
  parameter int TONE_HALF_CYC = 12500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CS_W-1:0]  cs,
  input  logic [LEN_W-1:0] on_len,
  input  logic [LEN_W-1:0] off_len,
  input  logic [CNT_W-1:0] burst_n,
  output logic             M,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_e           state, state_n;
  logic [CS_W-1:0]  mode_r, mode_n;
  logic [LEN_W-1:0] ph_cnt, ph_n, len_r, len_n;
  logic [CNT_W-1:0] beep_cnt, beep_n, n_r, n_nx;
  logic             done_n, tick_clr, tick, ph_last, m_n;
  mode_e            mode;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  // Codes above BURST are treated as OFF but still tracked raw so any cs edit restarts
  always_comb begin
    if (mode_r > CS_W'(3)) mode = MODE_OFF;
    else                   mode = mode_e'(mode_r[1:0]);
  end

  buzzer_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign ph_last = tick && (ph_cnt == len_r - LEN_W'(1));

  always_comb begin
    state_n  = state;
    mode_n   = mode_r;
    ph_n     = ph_cnt;
    len_n    = len_r;
    beep_n   = beep_cnt;
    n_nx     = n_r;
    done_n   = 1'b0;
    tick_clr = 1'b0;
    if (cs != mode_r) begin
      mode_n   = cs;
      state_n  = ST_IDLE;
      ph_n     = '0;
      len_n    = '0;
      beep_n   = '0;
      n_nx     = '0;
      tick_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          beep_n = '0;
          if (mode == MODE_CONT || mode == MODE_BEEP ||
              (mode == MODE_BURST && burst_n != '0)) begin
            state_n  = ST_ON;
            len_n    = eff_len(on_len);
            ph_n     = '0;
            tick_clr = 1'b1;
            if (mode == MODE_BURST) n_nx = burst_n;
          end else if (mode == MODE_BURST) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end
        ST_ON: begin
          // CONT never leaves ON, so its phase counter is frozen to avoid wrapping
          if (mode != MODE_CONT) begin
            if (ph_last) begin
              state_n  = ST_OFF;
              beep_n   = beep_cnt + CNT_W'(1);
              len_n    = eff_len(off_len);
              ph_n     = '0;
              tick_clr = 1'b1;
            end else if (tick) begin
              ph_n = ph_cnt + LEN_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (ph_last) begin
            if (mode == MODE_BURST && beep_cnt == n_r) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              state_n  = ST_ON;
              len_n    = eff_len(on_len);
              ph_n     = '0;
              tick_clr = 1'b1;
            end
          end else if (tick) begin
            ph_n = ph_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUZZER_TONE_EN
  localparam int TW = (TONE_HALF_CYC > 1) ? $clog2(TONE_HALF_CYC) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF_CYC - 1);

  logic [TW-1:0] tone_cnt, tone_cnt_n;
  logic          tone_r, tone_n;

  // Tone phase restarts high on every ON entry so each beep starts identically
  always_comb begin
    tone_cnt_n = tone_cnt;
    tone_n     = tone_r;
    if (state_n == ST_ON && tick_clr) begin
      tone_cnt_n = '0;
      tone_n     = 1'b1;
    end else if (state == ST_ON) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt_n = '0;
        tone_n     = ~tone_r;
      end else begin
        tone_cnt_n = tone_cnt + TW'(1);
      end
    end
    m_n = (state_n == ST_ON) && tone_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      tone_r   <= 1'b0;
    end else begin
      tone_cnt <= tone_cnt_n;
      tone_r   <= tone_n;
    end
  end
`else
  assign m_n = (state_n == ST_ON);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_r   <= CS_W'(MODE_OFF);
      ph_cnt   <= '0;
      len_r    <= '0;
      beep_cnt <= '0;
      n_r      <= '0;
      M        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mode_r   <= mode_n;
      ph_cnt   <= ph_n;
      len_r    <= len_n;
      beep_cnt <= beep_n;
      n_r      <= n_nx;
      M        <= m_n;
      busy     <= (state_n == ST_ON) || (state_n == ST_OFF);
      done     <= done_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// tb/tb_buzzer_pattern_gen.sv - directed self-checking bench for buzzer_pattern_gen (TICK_CYC=10)
module tb_buzzer_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cs;
  logic [11:0] on_len, off_len;
  logic [3:0]  burst_n;
  logic        m, busy, done;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  buzzer_pattern_gen #(
    .CS_W(3), .LEN_W(12), .CNT_W(4), .TICK_CYC(10), .TONE_HALF_CYC(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .on_len    (on_len),
    .off_len   (off_len),
    .burst_n   (burst_n),
    .M         (m),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count consecutive negedge samples with M==v, starting at the current sample
  task automatic run_len(input logic v, input int maxc, output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (m === v && n < maxc) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_high(input string tag);
    int c = 0;
    while (m !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(tag, m, 1);
  endtask

  int   n;
  logic bok;
  logic m_seen;

  initial begin
    rst_n = 1'b0; cs = 3'b010; on_len = 12'd3; off_len = 12'd2; burst_n = 4'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m", m, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, 0);

    rst_n = 1'b1;
    @(negedge clk); chk("rise_1st_edge", m, 0);
    @(negedge clk); chk("rise_2nd_edge", m, 1);
    chk("rise_state", state_dbg, 1);

    run_len(1'b1, 100, n, bok); chk("beep_on1", n, 30); chk("beep_busy_on", bok, 1);
    run_len(1'b0, 100, n, bok); chk("beep_off1", n, 20); chk("beep_busy_off", bok, 1);
    run_len(1'b1, 100, n, bok); chk("beep_on2", n, 30);

    cs = 3'b011; burst_n = 4'd2;
    @(negedge clk); chk("burst_idle", state_dbg, 0);
    wait_high("burst_start");
    run_len(1'b1, 100, n, bok); chk("burst_on1", n, 30);
    run_len(1'b0, 100, n, bok); chk("burst_off1", n, 20);
    run_len(1'b1, 100, n, bok); chk("burst_on2", n, 30);
    repeat (19) @(negedge clk);
    chk("burst_off2_state", state_dbg, 2);
    chk("burst_off2_done", done, 0);
    @(negedge clk);
    chk("burst_done_pulse", done, 1);
    chk("burst_done_state", state_dbg, 3);
    chk("burst_done_busy", busy, 0);
    @(negedge clk); chk("burst_done_1cyc", done, 0);
    repeat (5) @(negedge clk);
    chk("burst_hold_m", m, 0);
    chk("burst_hold_state", state_dbg, 3);

    cs = 3'b010;
    wait_high("sw_start");
    repeat (14) @(negedge clk);
    cs = 3'b001;
    @(negedge clk); chk("sw_gap", m, 0);
    @(negedge clk); chk("sw_cont_rise", m, 1);
    run_len(1'b1, 60, n, bok); chk("cont_hold", n, 60);

    rst_n = 1'b0;
    @(negedge clk); chk("midrst_m", m, 0); chk("midrst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk); chk("midrst_1st", m, 0);
    @(negedge clk); chk("midrst_2nd", m, 1);

    on_len = 12'd0; off_len = 12'd0; cs = 3'b010;
    @(negedge clk);
    wait_high("zero_start");
    run_len(1'b1, 100, n, bok); chk("zero_on", n, 10);
    run_len(1'b0, 100, n, bok); chk("zero_off", n, 10);

    cs = 3'b011; burst_n = 4'd0; m_seen = 1'b0;
    @(negedge clk); m_seen |= m; chk("b0_done_early", done, 0);
    @(negedge clk); m_seen |= m; chk("b0_done", done, 1); chk("b0_state", state_dbg, 3);
    repeat (10) begin
      @(negedge clk);
      m_seen |= m;
    end
    chk("b0_m_never", m_seen, 0);

`ifdef BUZZER_TONE_EN
    on_len = 12'd2; off_len = 12'd2; cs = 3'b010;
    @(negedge clk);
    wait_high("tone_start");
    for (int i = 0; i < 5; i++) begin
      run_len(m, 100, n, bok);
      chk($sformatf("tone_seg%0d", i), n, 4);
    end
    run_len(1'b0, 100, n, bok); chk("tone_off", n, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
